// File: rtl/seg_display_driver.sv
// rtl/seg_display_driver.sv - four-digit multiplexed hex display of captured PC/ALU words with a debounced page button
// Optional leading-zero blanking when DISP_BLANK_ZERO_EN is defined.
module seg_display_driver #(
   parameter int REFRESH_DIV  = 100000,
   parameter int DEBOUNCE_CYC = 1000000
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic [15:0] pc_in,
   input  logic [15:0] alu_in,
   input  logic        capture,
   input  logic        page_btn,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        page
);

   localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int DEB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

   logic [15:0]      pc_q;
   logic [15:0]      alu_q;
   logic [1:0]       sync_q;
   logic             btn_acc;
   logic [DEB_W-1:0] deb_cnt;
   logic             page_q;
   logic [REF_W-1:0] ref_cnt;
   logic [1:0]       k;

   logic [15:0]      word;
   logic [3:0]       nibble;
   logic             blank;
   logic [3:0]       an_d;
   logic [6:0]       seg_d;
   logic             dp_d;
   logic [3:0]       an_q;
   logic [6:0]       seg_q;
   logic             dp_q;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_ff @(posedge clock_in) begin
      if (reset) begin
         pc_q  <= '0;
         alu_q <= '0;
      end else if (capture) begin
         pc_q  <= pc_in;
         alu_q <= alu_in;
      end
   end

   // Page toggles only on the accepted rising level, so a held button cannot re-toggle.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         sync_q  <= '0;
         btn_acc <= 1'b0;
         deb_cnt <= '0;
         page_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], page_btn};
         if (sync_q[1] == btn_acc) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            btn_acc <= sync_q[1];
            deb_cnt <= '0;
            if (sync_q[1]) begin
               page_q <= ~page_q;
            end
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         ref_cnt <= '0;
         k       <= 2'd0;
      end else if (ref_cnt == REF_LAST) begin
         ref_cnt <= '0;
         k       <= k + 2'd1;
      end else begin
         ref_cnt <= ref_cnt + REF_W'(1);
      end
   end

   assign word = page_q ? alu_q : pc_q;

   always_comb begin
      nibble = word[3:0];
      case (k)
         2'd0: nibble = word[3:0];
         2'd1: nibble = word[7:4];
         2'd2: nibble = word[11:8];
         default: nibble = word[15:12];
      endcase
   end

`ifdef DISP_BLANK_ZERO_EN
   // A digit is a leading zero when it and every more-significant nibble are zero.
   always_comb begin
      blank = 1'b0;
      case (k)
         2'd1: blank = (word[15:4] == 12'h000);
         2'd2: blank = (word[15:8] == 8'h00);
         2'd3: blank = (word[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
      if (!blank) begin
         an_d  = ~(4'b0001 << k);
         seg_d = hex_to_seg(nibble);
      end
      if (k == 2'd3 && page_q) begin
         dp_d = 1'b0;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         an_q  <= 4'b1111;
         seg_q <= 7'b1111111;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an   = an_q;
   assign seg  = seg_q;
   assign dp   = dp_q;
   assign page = page_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// tb/tb_seg_display_driver.sv - directed self-checking bench for seg_display_driver (REFRESH_DIV=4, DEBOUNCE_CYC=8)
module tb_seg_display_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pc_in;
   logic [15:0] alu_in;
   logic        capture;
   logic        page_btn;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        page;

   int checks   = 0;
   int failures = 0;

   localparam logic [6:0] HEX_TBL [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   localparam logic [3:0] AN_EXP [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   seg_display_driver #(.REFRESH_DIV(4), .DEBOUNCE_CYC(8)) dut (
      .clock_in (clk),
      .reset    (reset),
      .pc_in    (pc_in),
      .alu_in   (alu_in),
      .capture  (capture),
      .page_btn (page_btn),
      .an       (an),
      .seg      (seg),
      .dp       (dp),
      .page     (page)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      reset    = 1'b1;
      capture  = 1'b0;
      page_btn = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_capture(input logic [15:0] pc, input logic [15:0] alu);
      pc_in   = pc;
      alu_in  = alu;
      capture = 1'b1;
      @(negedge clk);
      capture = 1'b0;
   endtask

   // Waits until the first sample at which an becomes target.
   task automatic sync_an(input logic [3:0] target, output bit ok);
      logic [3:0] prev;
      ok   = 1'b0;
      prev = an;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (prev !== target && an === target) begin
            ok = 1'b1;
            break;
         end
         prev = an;
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      capture  = 1'b0;
      page_btn = 1'b0;
      pc_in    = 16'h1234;
      alu_in   = 16'h5678;
      repeat (3) @(negedge clk);
      checks++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || page !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs an=%b seg=%b dp=%b page=%b expected 1111 1111111 1 0", an, seg, dp, page);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (an !== 4'b1110 || seg !== HEX_TBL[0] || dp !== 1'b1) begin
         failures++;
         $display("FAIL first_digit an=%b seg=%b dp=%b expected 1110 %b 1", an, seg, dp, HEX_TBL[0]);
      end
   endtask

   task automatic test_scan();
      bit ok;
      logic [3:0] nib [4] = '{4'hF, 4'hA, 4'h2, 4'h1};
      do_reset();
      do_capture(16'h12AF, 16'h0000);
      sync_an(4'b1110, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL scan_sync an=%b never reached 1110", an);
      end
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            checks++;
            if (an !== AN_EXP[d] || seg !== HEX_TBL[nib[d]] || dp !== 1'b1) begin
               failures++;
               $display("FAIL scan d%0d c%0d an=%b seg=%b dp=%b expected %b %b 1", d, c, an, seg, dp, AN_EXP[d], HEX_TBL[nib[d]]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_page();
      bit ok;
      logic [3:0] nib [4] = '{4'hF, 4'hE, 4'hE, 4'hB};
      do_capture(16'h12AF, 16'hBEEF);
      page_btn = 1'b1;
      repeat (9) @(negedge clk);
      checks++;
      if (page !== 1'b0) begin
         failures++;
         $display("FAIL page_early page=%b expected 0", page);
      end
      @(negedge clk);
      checks++;
      if (page !== 1'b1) begin
         failures++;
         $display("FAIL page_toggle page=%b expected 1", page);
      end
      repeat (2) @(negedge clk);
      page_btn = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (page !== 1'b1) begin
         failures++;
         $display("FAIL page_release page=%b expected 1", page);
      end
      sync_an(4'b1110, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL page_sync an=%b never reached 1110", an);
      end
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            checks++;
            if (an !== AN_EXP[d] || seg !== HEX_TBL[nib[d]] || dp !== (d == 3 ? 1'b0 : 1'b1)) begin
               failures++;
               $display("FAIL alu_scan d%0d c%0d an=%b seg=%b dp=%b expected %b %b %b", d, c, an, seg, dp, AN_EXP[d], HEX_TBL[nib[d]], (d == 3 ? 1'b0 : 1'b1));
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_glitch();
      page_btn = 1'b1;
      repeat (5) @(negedge clk);
      page_btn = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (page !== 1'b1) begin
         failures++;
         $display("FAIL glitch page=%b expected 1", page);
      end
      page_btn = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (page !== 1'b0) begin
         failures++;
         $display("FAIL long_hold page=%b expected 0", page);
      end
      page_btn = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (page !== 1'b0) begin
         failures++;
         $display("FAIL hold_release page=%b expected 0", page);
      end
   endtask

   task automatic test_no_capture();
      bit ok;
      logic [3:0] nib [4] = '{4'hF, 4'hA, 4'h2, 4'h1};
      sync_an(4'b1110, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL nocap_sync an=%b never reached 1110", an);
      end
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            checks++;
            if (seg !== HEX_TBL[nib[d]]) begin
               failures++;
               $display("FAIL nocap d%0d c%0d seg=%b expected %b", d, c, seg, HEX_TBL[nib[d]]);
            end
            pc_in  = 16'($urandom);
            alu_in = 16'($urandom);
            @(negedge clk);
         end
      end
      sync_an(4'b1110, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL cap_sync an=%b never reached 1110", an);
      end
      pc_in   = 16'h12A7;
      capture = 1'b1;
      @(negedge clk);
      capture = 1'b0;
      checks++;
      if (seg !== HEX_TBL[4'hF]) begin
         failures++;
         $display("FAIL cap_latency seg=%b expected %b", seg, HEX_TBL[4'hF]);
      end
      @(negedge clk);
      checks++;
      if (seg !== HEX_TBL[4'h7]) begin
         failures++;
         $display("FAIL cap_visible seg=%b expected %b", seg, HEX_TBL[4'h7]);
      end
   endtask

   task automatic test_blank();
      bit ok;
      logic [3:0] nib [4] = '{4'h0, 4'h3, 4'h0, 4'h0};
      logic [3:0] an_e;
      logic [6:0] seg_e;
      do_capture(16'h0030, 16'h0000);
      sync_an(4'b1110, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL blank_sync an=%b never reached 1110", an);
      end
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            an_e  = AN_EXP[d];
            seg_e = HEX_TBL[nib[d]];
`ifdef DISP_BLANK_ZERO_EN
            if (d >= 2) begin
               an_e  = 4'b1111;
               seg_e = 7'b1111111;
            end
`endif
            checks++;
            if (an !== an_e || seg !== seg_e || dp !== 1'b1) begin
               failures++;
               $display("FAIL blank d%0d c%0d an=%b seg=%b dp=%b expected %b %b 1", d, c, an, seg, dp, an_e, seg_e);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      bit ok;
      do_capture(16'h4321, 16'h0000);
      sync_an(4'b1011, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL midscan_sync an=%b never reached 1011", an);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
         failures++;
         $display("FAIL midscan_reset an=%b seg=%b dp=%b expected 1111 1111111 1", an, seg, dp);
      end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (an !== 4'b1110 || seg !== HEX_TBL[0]) begin
            failures++;
            $display("FAIL restart c%0d an=%b seg=%b expected 1110 %b", c, an, seg, HEX_TBL[0]);
         end
      end
      @(negedge clk);
      checks++;
      if (an !== 4'b1101) begin
         failures++;
         $display("FAIL restart_advance an=%b expected 1101", an);
      end
   endtask

   task automatic test_reset_mid_debounce();
      page_btn = 1'b1;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (page !== 1'b0) begin
         failures++;
         $display("FAIL debounce_reset page=%b expected 0", page);
      end
      repeat (9) @(negedge clk);
      checks++;
      if (page !== 1'b0) begin
         failures++;
         $display("FAIL debounce_restart_early page=%b expected 0", page);
      end
      @(negedge clk);
      checks++;
      if (page !== 1'b1) begin
         failures++;
         $display("FAIL debounce_restart_toggle page=%b expected 1", page);
      end
      page_btn = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      capture  = 1'b0;
      page_btn = 1'b0;
      pc_in    = '0;
      alu_in   = '0;
      @(negedge clk);
      test_reset();
      test_scan();
      test_page();
      test_glitch();
      test_no_capture();
      test_blank();
      test_reset_mid_scan();
      test_reset_mid_debounce();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
